// File: rtl/cpu_sel_pkg.sv
// Shared types for the CPU destination-select path: sequencer state
// encoding, the named destination codes of the register file / special
// registers, and default widths.
package cpu_sel_pkg;

  localparam int DEF_SEL_W    = 4;
  localparam int DEF_NUM_DEST = 9;

  // Sequencer state: IDLE has no enable active, DRIVE holds one enable high.
  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Destination codes as issued by the control unit; 0 is the null code.
  typedef enum logic [3:0] {
    CODE_NOP = 4'd0,
    CODE_R1  = 4'd1,
    CODE_R2  = 4'd2,
    CODE_R3  = 4'd3,
    CODE_R4  = 4'd4,
    CODE_R5  = 4'd5,
    CODE_AR  = 4'd6,
    CODE_AC  = 4'd7,
    CODE_IR  = 4'd8,
    CODE_PC  = 4'd9
  } dest_code_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational destination decoder: classifies a select code as below the
// base (null), in range (one-hot enable) or above range (error).
// Range comparisons use one extra bit so BASE_CODE+NUM_DEST == 2**SEL_W is
// representable; the index subtraction happens only at SEL_W bits.
module onehot_dec #(
  parameter int SEL_W     = 4,
  parameter int NUM_DEST  = 9,
  parameter int BASE_CODE = 1
) (
  input  logic [SEL_W-1:0]    code,
  output logic                in_range,
  output logic                below_base,
  output logic [NUM_DEST-1:0] onehot
);

  localparam logic [SEL_W:0]   LO_X   = (SEL_W+1)'(BASE_CODE);
  localparam logic [SEL_W:0]   HI_X   = (SEL_W+1)'(BASE_CODE + NUM_DEST);
  localparam logic [SEL_W-1:0] BASE_W = SEL_W'(BASE_CODE);

  logic [SEL_W:0]   code_x;
  logic [SEL_W-1:0] idx;

  assign code_x     = {1'b0, code};
  assign below_base = (code_x < LO_X);
  assign in_range   = !below_base && (code_x < HI_X);
  assign idx        = code - BASE_W;

  // Build the one-hot vector; all zero unless the code is in range.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      onehot[i] = in_range && (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/reg_write_sequencer.sv
// Registered, handshaked destination decoder driving one-hot write enables
// for R1..R5, AR, AC, IR and PC. Each accepted in-range code produces
// exactly HOLD_CYCLES enabled cycles; back-to-back codes hand over with no
// gap. Optional saturating error counter enabled by SEL_ERR_COUNT_EN.
//
// Handshake: a code transfers on a rising edge where sel_valid and
// sel_ready are both high. sel_ready is a function of state only (never of
// sel_valid); a code offered while sel_ready is low is ignored, not queued.
module reg_write_sequencer
  import cpu_sel_pkg::*;
#(
  parameter int SEL_W       = DEF_SEL_W,
  parameter int NUM_DEST    = DEF_NUM_DEST,
  parameter int BASE_CODE   = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_code,
  output logic                sel_ready,
  output logic [NUM_DEST-1:0] en_onehot,
  output logic                en_valid,
  output logic                sel_err,
  output logic [7:0]          err_count,
  output logic                dbg_state
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  if (BASE_CODE + NUM_DEST > (1 << SEL_W)) begin : g_bad_range
    $error("reg_write_sequencer: BASE_CODE+NUM_DEST exceeds 2**SEL_W");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reg_write_sequencer: HOLD_CYCLES must be >= 1");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               dec_in_range;
  logic               dec_below_base;
  logic [NUM_DEST-1:0] dec_onehot;

  onehot_dec #(
    .SEL_W    (SEL_W),
    .NUM_DEST (NUM_DEST),
    .BASE_CODE(BASE_CODE)
  ) u_dec (
    .code      (sel_code),
    .in_range  (dec_in_range),
    .below_base(dec_below_base),
    .onehot    (dec_onehot)
  );

  assign sel_ready = (state == IDLE) || ((state == DRIVE) && (cnt == '0));
  assign accept    = sel_valid && sel_ready;
  assign dbg_state = state;

  // Sequencer FSM: classify accepted codes, hold the enable, hand over.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      en_onehot <= '0;
      en_valid  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      if (accept) begin
        if (dec_in_range) begin
          state     <= DRIVE;
          cnt       <= CNT_LOAD;
          en_onehot <= dec_onehot;
          en_valid  <= 1'b1;
        end else begin
          state     <= IDLE;
          cnt       <= '0;
          en_onehot <= '0;
          en_valid  <= 1'b0;
          sel_err   <= !dec_below_base;
        end
      end else if (state == DRIVE) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state     <= IDLE;
          en_onehot <= '0;
          en_valid  <= 1'b0;
        end
      end
    end
  end

`ifdef SEL_ERR_COUNT_EN
  logic [7:0] err_q;

  // Saturating count of sel_err pulses; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 8'd0;
    end else if (sel_err && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
